// File: rtl/pb_port_master.sv
// KCPSM6-style I/O port bus initiator: queued OUTPUT/INPUT commands issued with
// two-cycle bus timing, read data returned on a response strobe, interrupts acked between transactions.
module pb_port_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_port,
    output logic [7:0] rsp_rdata,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    input  logic       interrupt,
    output logic       interrupt_ack,
    output logic       busy,
    output logic [7:0] int_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
    localparam bit GAP_EN = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_STRB   = 3'd2,
        ST_GAP    = 3'd3,
        ST_INTACK = 3'd4
    } state_t;

    logic [16:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    logic          int_armed_r;
    logic [3:0]    gap_cnt_r;
    logic          cur_write_r;
    logic [7:0]    port_id_r;
    logic [7:0]    out_port_r;
    logic          write_strobe_r;
    logic          read_strobe_r;
    logic          rsp_valid_r;
    logic [7:0]    rsp_port_r;
    logic [7:0]    rsp_rdata_r;
    logic          int_ack_r;
    logic [7:0]    int_count_r;

    logic          push_s;
    logic          pop_s;
    logic          int_req_s;
    logic [16:0]   head_s;

    assign push_s    = cmd_valid && (count_r != COUNT_FULL);
    assign int_req_s = interrupt && int_armed_r;
    assign head_s    = mem_r[rd_ptr_r];

    // Pop decision: only from IDLE or a back-to-back STRB, and never while an ack is due.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !int_req_s && (count_r != '0);
            ST_STRB: pop_s = !GAP_EN && !int_req_s && (count_r != '0);
            default: pop_s = 1'b0;
        endcase
    end

    // Command storage; entries are {write, port, wdata}.
    always_ff @(posedge sysclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_write, cmd_port, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Bus sequencer with registered bus, response and interrupt outputs.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_r        <= ST_IDLE;
            int_armed_r    <= 1'b1;
            gap_cnt_r      <= 4'd0;
            cur_write_r    <= 1'b0;
            port_id_r      <= 8'h00;
            out_port_r     <= 8'h00;
            write_strobe_r <= 1'b0;
            read_strobe_r  <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_port_r     <= 8'h00;
            rsp_rdata_r    <= 8'h00;
            int_ack_r      <= 1'b0;
            int_count_r    <= 8'h00;
        end else begin
            write_strobe_r <= 1'b0;
            read_strobe_r  <= 1'b0;
            rsp_valid_r    <= 1'b0;
            int_ack_r      <= 1'b0;
            // Re-arm on any low sample so each high episode is acked once.
            if (!interrupt) begin
                int_armed_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (int_req_s) begin
                        state_r     <= ST_INTACK;
                        int_ack_r   <= 1'b1;
                        int_count_r <= int_count_r + 8'd1;
                        int_armed_r <= 1'b0;
                    end else if (pop_s) begin
                        state_r     <= ST_ADDR;
                        cur_write_r <= head_s[16];
                        port_id_r   <= head_s[15:8];
                        if (head_s[16]) begin
                            out_port_r <= head_s[7:0];
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    state_r        <= ST_STRB;
                    write_strobe_r <= cur_write_r;
                    read_strobe_r  <= !cur_write_r;
                end
                ST_STRB: begin
                    if (!cur_write_r) begin
                        rsp_valid_r <= 1'b1;
                        rsp_port_r  <= port_id_r;
                        rsp_rdata_r <= in_port;
                    end
                    if (GAP_EN) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= GAP_LOAD;
                    end else if (int_req_s) begin
                        state_r     <= ST_INTACK;
                        int_ack_r   <= 1'b1;
                        int_count_r <= int_count_r + 8'd1;
                        int_armed_r <= 1'b0;
                    end else if (pop_s) begin
                        state_r     <= ST_ADDR;
                        cur_write_r <= head_s[16];
                        port_id_r   <= head_s[15:8];
                        if (head_s[16]) begin
                            out_port_r <= head_s[7:0];
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                ST_INTACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (count_r != COUNT_FULL);
    assign busy          = (state_r != ST_IDLE) || (count_r != '0);
    assign port_id       = port_id_r;
    assign out_port      = out_port_r;
    assign write_strobe  = write_strobe_r;
    assign read_strobe   = read_strobe_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_port      = rsp_port_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign interrupt_ack = int_ack_r;
    assign int_count     = int_count_r;

endmodule

// File: tb/tb_pb_port_master.sv
// Self-checking bench for pb_port_master: directed latency table, multi-cycle corner
// sequences on three parameterisations, and a randomized run against a queue-based model.
module tb_pb_port_master;

    logic       clk_s = 1'b0;
    logic       rst_s = 1'b1;
    logic       cmd_write_s = 1'b0;
    logic [7:0] cmd_port_s = 8'h00;
    logic [7:0] cmd_wdata_s = 8'h00;
    logic [7:0] in_port_s = 8'h00;

    logic       valid0_s = 1'b0, int0_s = 1'b0;
    logic       ready0_s, rspv0_s, wstb0_s, rstb0_s, ack0_s, busy0_s;
    logic [7:0] rspp0_s, rspd0_s, pid0_s, outp0_s, icnt0_s;

    logic       valid2_s = 1'b0, int2_s = 1'b0;
    logic       ready2_s, rspv2_s, wstb2_s, rstb2_s, ack2_s, busy2_s;
    logic [7:0] rspp2_s, rspd2_s, pid2_s, outp2_s, icnt2_s;

    logic       valid15_s = 1'b0, int15_s = 1'b0;
    logic       ready15_s, rspv15_s, wstb15_s, rstb15_s, ack15_s, busy15_s;
    logic [7:0] rspp15_s, rspd15_s, pid15_s, outp15_s, icnt15_s;

    always #5 clk_s = ~clk_s;

    pb_port_master #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .sysclk(clk_s), .sysreset(rst_s), .cmd_valid(valid0_s), .cmd_ready(ready0_s),
        .cmd_write(cmd_write_s), .cmd_port(cmd_port_s), .cmd_wdata(cmd_wdata_s),
        .rsp_valid(rspv0_s), .rsp_port(rspp0_s), .rsp_rdata(rspd0_s),
        .port_id(pid0_s), .out_port(outp0_s), .write_strobe(wstb0_s), .read_strobe(rstb0_s),
        .in_port(in_port_s), .interrupt(int0_s), .interrupt_ack(ack0_s),
        .busy(busy0_s), .int_count(icnt0_s));

    pb_port_master #(.FIFO_DEPTH(4), .GAP_CYCLES(2)) dut2 (
        .sysclk(clk_s), .sysreset(rst_s), .cmd_valid(valid2_s), .cmd_ready(ready2_s),
        .cmd_write(cmd_write_s), .cmd_port(cmd_port_s), .cmd_wdata(cmd_wdata_s),
        .rsp_valid(rspv2_s), .rsp_port(rspp2_s), .rsp_rdata(rspd2_s),
        .port_id(pid2_s), .out_port(outp2_s), .write_strobe(wstb2_s), .read_strobe(rstb2_s),
        .in_port(in_port_s), .interrupt(int2_s), .interrupt_ack(ack2_s),
        .busy(busy2_s), .int_count(icnt2_s));

    pb_port_master #(.FIFO_DEPTH(4), .GAP_CYCLES(15)) dut15 (
        .sysclk(clk_s), .sysreset(rst_s), .cmd_valid(valid15_s), .cmd_ready(ready15_s),
        .cmd_write(cmd_write_s), .cmd_port(cmd_port_s), .cmd_wdata(cmd_wdata_s),
        .rsp_valid(rspv15_s), .rsp_port(rspp15_s), .rsp_rdata(rspd15_s),
        .port_id(pid15_s), .out_port(outp15_s), .write_strobe(wstb15_s), .read_strobe(rstb15_s),
        .in_port(in_port_s), .interrupt(int15_s), .interrupt_ack(ack15_s),
        .busy(busy15_s), .int_count(icnt15_s));

    typedef struct {
        logic       wr;
        logic [7:0] port;
        logic [7:0] wdata;
        logic [7:0] din;
        logic [7:0] exp_out;
        logic       exp_rspv;
        logic [7:0] exp_rdata;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] exp_out0 = 8'h00;
    logic [7:0] exp_int = 8'h00;

    // model state for the randomized run
    logic [16:0] q[$];
    logic        pend = 1'b0;
    logic [7:0]  pend_port = 8'h00;
    logic [7:0]  pend_data = 8'h00;
    logic        ack_prev = 1'b0;
    int          hi_left = 0;
    int          lo_cnt = 0;
    int          episodes = 0;
    int          acks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        @(negedge clk_s);
        cyc++;
    endtask

    task automatic rnd_step(input bit allow_new);
        logic        rdy;
        logic        v;
        logic [16:0] c;
        logic [16:0] h;
        valid0_s    = allow_new && ($urandom_range(0, 1) == 1);
        cmd_write_s = 1'($urandom_range(0, 1));
        cmd_port_s  = 8'($urandom);
        cmd_wdata_s = 8'($urandom);
        in_port_s   = 8'($urandom);
        if (pend) pend_data = in_port_s;
        if (int0_s) begin
            hi_left--;
            if (hi_left == 0) begin
                int0_s = 1'b0;
                lo_cnt = 0;
            end
        end else begin
            lo_cnt++;
            if (allow_new && lo_cnt >= 3 && $urandom_range(0, 19) == 0) begin
                int0_s  = 1'b1;
                hi_left = 8;
                exp_int = exp_int + 8'd1;
                episodes++;
            end
        end
        rdy = ready0_s;
        v   = valid0_s;
        c   = {cmd_write_s, cmd_port_s, cmd_wdata_s};
        tick();
        if (v && rdy) q.push_back(c);
        chk("rnd_rsp_valid", rspv0_s, pend);
        if (pend) begin
            chk("rnd_rsp_port", rspp0_s, pend_port);
            chk("rnd_rsp_rdata", rspd0_s, pend_data);
        end
        pend = 1'b0;
        if (wstb0_s || rstb0_s) begin
            chk("rnd_both_strobes", wstb0_s & rstb0_s, 1'b0);
            if (q.size() == 0) begin
                chk("rnd_unexpected_txn", 32'd1, 32'd0);
            end else begin
                h = q.pop_front();
                chk("rnd_strobe_kind", wstb0_s, h[16]);
                chk("rnd_port_id", pid0_s, h[15:8]);
                if (h[16]) exp_out0 = h[7:0];
                chk("rnd_out_port", outp0_s, exp_out0);
                if (!h[16]) begin
                    pend      = 1'b1;
                    pend_port = h[15:8];
                end
            end
        end
        if (ack0_s) begin
            acks++;
            chk("rnd_ack_one_cycle", ack_prev, 1'b0);
        end
        ack_prev = ack0_s;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] got_port[$];
        int         got_cyc[$];
        bit         seen;
        bit         any;

        vecs[0] = '{1'b1, 8'h02, 8'hA5, 8'h00, 8'hA5, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h0A, 8'hEE, 8'h3C, 8'hA5, 1'b1, 8'h3C};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h77, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 8'h99, 8'hFF, 8'h00, 1'b1, 8'hFF};
        vecs[4] = '{1'b1, 8'h80, 8'h5A, 8'h12, 8'h5A, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 8'h7F, 8'h11, 8'hC3, 8'h5A, 1'b1, 8'hC3};

        repeat (3) @(negedge clk_s);
        rst_s = 1'b0;
        tick();

        // reset state
        chk("rst_cmd_ready", ready0_s, 1'b1);
        chk("rst_busy", busy0_s, 1'b0);
        chk("rst_int_count", icnt0_s, 8'h00);
        chk("rst_port_id", pid0_s, 8'h00);
        chk("rst_out_port", outp0_s, 8'h00);
        chk("rst_rsp", {rspv0_s, rspp0_s, rspd0_s}, 17'h0);
        chk("rst_strobes_ack", {wstb0_s, rstb0_s, ack0_s}, 3'b000);

        // single-command latency table
        for (int i = 0; i < 6; i++) begin
            valid0_s = 1'b1; cmd_write_s = vecs[i].wr;
            cmd_port_s = vecs[i].port; cmd_wdata_s = vecs[i].wdata; in_port_s = vecs[i].din;
            tick();
            valid0_s = 1'b0;
            tick();
            chk("tbl_e1_port_id", pid0_s, vecs[i].port);
            chk("tbl_e1_out_port", outp0_s, vecs[i].exp_out);
            chk("tbl_e1_strobes", {wstb0_s, rstb0_s}, 2'b00);
            chk("tbl_e1_busy", busy0_s, 1'b1);
            tick();
            chk("tbl_e2_wstb", wstb0_s, vecs[i].wr);
            chk("tbl_e2_rstb", rstb0_s, !vecs[i].wr);
            chk("tbl_e2_port_id", pid0_s, vecs[i].port);
            chk("tbl_e2_out_port", outp0_s, vecs[i].exp_out);
            tick();
            chk("tbl_e3_strobes", {wstb0_s, rstb0_s}, 2'b00);
            chk("tbl_e3_rsp_valid", rspv0_s, vecs[i].exp_rspv);
            if (vecs[i].exp_rspv) begin
                chk("tbl_e3_rsp_port", rspp0_s, vecs[i].port);
                chk("tbl_e3_rsp_rdata", rspd0_s, vecs[i].exp_rdata);
            end
            tick();
            chk("tbl_e4_rsp_valid", rspv0_s, 1'b0);
            chk("tbl_e4_busy", busy0_s, 1'b0);
            exp_out0 = vecs[i].exp_out;
        end

        // GAP_CYCLES=0: four queued writes issued every 2 cycles
        got_port.delete(); got_cyc.delete();
        for (int t = 0; t < 16; t++) begin
            valid0_s = (t < 4); cmd_write_s = 1'b1;
            cmd_port_s = 8'h61 + 8'(t); cmd_wdata_s = 8'h11 * 8'(t + 1);
            tick();
            if (wstb0_s) begin
                got_port.push_back(pid0_s);
                got_cyc.push_back(cyc);
            end
        end
        valid0_s = 1'b0;
        exp_out0 = 8'h44;
        chk("b2b_count", got_port.size(), 4);
        if (got_port.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("b2b_order", got_port[k], 8'h61 + 8'(k));
            for (int k = 1; k < 4; k++) chk("b2b_spacing", got_cyc[k] - got_cyc[k-1], 2);
        end

        // interrupt raised during ADDR of a read
        valid0_s = 1'b1; cmd_write_s = 1'b0; cmd_port_s = 8'h33; in_port_s = 8'h44;
        tick();
        valid0_s = 1'b0;
        tick();
        int0_s = 1'b1; exp_int = exp_int + 8'd1;
        tick();
        chk("irq_txn_strobe", rstb0_s, 1'b1);
        chk("irq_no_early_ack", ack0_s, 1'b0);
        tick();
        chk("irq_rsp_valid", rspv0_s, 1'b1);
        chk("irq_rsp_rdata", rspd0_s, 8'h44);
        chk("irq_ack", ack0_s, 1'b1);
        chk("irq_count1", icnt0_s, exp_int);
        tick();
        chk("irq_ack_one_cycle", ack0_s, 1'b0);
        any = 1'b0;
        repeat (10) begin tick(); any = any | ack0_s; end
        chk("irq_held_no_reack", any, 1'b0);
        chk("irq_count_held", icnt0_s, exp_int);
        int0_s = 1'b0;
        tick(); tick();
        int0_s = 1'b1; exp_int = exp_int + 8'd1;
        seen = 1'b0;
        for (int t = 0; t < 5 && !seen; t++) begin tick(); seen = ack0_s; end
        chk("irq_second_ack_seen", seen, 1'b1);
        chk("irq_count2", icnt0_s, exp_int);
        int0_s = 1'b0;
        for (int e = 0; e < 254; e++) begin
            tick(); tick();
            int0_s = 1'b1; exp_int = exp_int + 8'd1;
            tick(); tick(); tick();
            int0_s = 1'b0;
        end
        tick(); tick();
        chk("irq_count_wrap", icnt0_s, 8'h00);
        chk("irq_model_wrap", exp_int, 8'h00);

        // GAP_CYCLES=2: second ADDR three cycles after first STRB ends
        valid2_s = 1'b1; cmd_write_s = 1'b1; cmd_port_s = 8'h51; cmd_wdata_s = 8'h01;
        tick();
        cmd_port_s = 8'h52; cmd_wdata_s = 8'h02;
        tick();
        valid2_s = 1'b0;
        got_port.delete(); got_cyc.delete();
        repeat (20) begin
            tick();
            if (wstb2_s) begin
                got_port.push_back(pid2_s);
                got_cyc.push_back(cyc);
            end
        end
        chk("gap2_count", got_port.size(), 2);
        if (got_port.size() == 2) begin
            chk("gap2_first_port", got_port[0], 8'h51);
            chk("gap2_second_port", got_port[1], 8'h52);
            chk("gap2_strobe_spacing", got_cyc[1] - got_cyc[0], 5);
        end

        // GAP_CYCLES=15: fill the FIFO while the master sits in GAP
        valid15_s = 1'b1; cmd_write_s = 1'b1; cmd_port_s = 8'h10; cmd_wdata_s = 8'h00;
        tick();
        valid15_s = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            valid15_s = 1'b1; cmd_port_s = 8'h20 + 8'(i); cmd_wdata_s = 8'(i);
            chk("full_cmd_ready", ready15_s, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        valid15_s = 1'b0;
        chk("full_ready_low", ready15_s, 1'b0);
        chk("full_busy", busy15_s, 1'b1);
        got_port.delete();
        repeat (130) begin
            tick();
            if (wstb15_s) got_port.push_back(pid15_s);
        end
        chk("full_issued_count", got_port.size(), 4);
        if (got_port.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("full_order", got_port[k], 8'h20 + 8'(k));
        end
        chk("full_drained_ready", ready15_s, 1'b1);

        // randomized traffic with interrupt episodes against the queue model
        lo_cnt = 0;
        for (int i = 0; i < 3000; i++) rnd_step(1'b1);
        for (int i = 0; i < 100 && (q.size() != 0 || pend || int0_s); i++) rnd_step(1'b0);
        repeat (4) rnd_step(1'b0);
        chk("rnd_queue_drained", q.size(), 0);
        chk("rnd_ack_count", acks, episodes);
        chk("rnd_int_count", icnt0_s, exp_int);

        // asynchronous reset during STRB with two commands queued
        for (int i = 0; i < 3; i++) begin
            valid0_s = 1'b1; cmd_write_s = 1'b1; cmd_port_s = 8'h90 + 8'(i); cmd_wdata_s = 8'h5C;
            tick();
        end
        valid0_s = 1'b0;
        chk("mid_strb_precond", wstb0_s, 1'b1);
        #2;
        rst_s = 1'b1;
        #1;
        chk("async_rst_strobes", {wstb0_s, rstb0_s, ack0_s}, 3'b000);
        chk("async_rst_cmd_ready", ready0_s, 1'b1);
        chk("async_rst_busy", busy0_s, 1'b0);
        chk("async_rst_rsp_valid", rspv0_s, 1'b0);
        chk("async_rst_port_id", pid0_s, 8'h00);
        tick(); tick();
        rst_s = 1'b0;
        any = 1'b0;
        repeat (10) begin
            tick();
            any = any | wstb0_s | rstb0_s | rspv0_s | busy0_s;
        end
        chk("post_rst_nothing_issued", any, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
